// File: rtl/wr_ingress_ctrl_if.sv
// Upstream valid/ready stream into the write-side ingress stage.
//   s_valid : producer has a beat on s_data
//   s_data  : beat payload
//   s_ready : consumer can take a beat this cycle
// master = producer side, slave = wr_ingress_ctrl side.
interface wr_ingress_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress stage of the async FIFO.
// Buffers the upstream stream in a 2-entry skid buffer, presents beats to the write-pointer
// handler (w_en/wdata), synchronises the gray read pointer into wclk, and tracks fill level,
// almost_full and a saturating full-stall counter.
// Ports:
//   wclk, wrst_n  : write clock, async active-low reset
//   s             : upstream stream (slave modport: s_valid, s_data in; s_ready out, registered)
//   g_rptr_async  : gray read pointer from read domain
//   g_rptr_sync   : synchronised gray read pointer, to pointer handler
//   b_wptr        : binary write pointer from pointer handler
//   full          : registered full from pointer handler
//   w_en, wdata   : write request and data
//   wlevel        : registered fill level 0..DEPTH
//   almost_full   : registered wlevel >= AF_THRESH
//   stall_cnt     : saturating count of cycles with data waiting while full
//   stall_clr     : synchronous clear of stall_cnt, wins over increment
module wr_ingress_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PTR_WIDTH   = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_THRESH   = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    wr_ingress_ctrl_if.slave      s,
    input  logic [PTR_WIDTH:0]    g_rptr_async,
    output logic [PTR_WIDTH:0]    g_rptr_sync,
    input  logic [PTR_WIDTH:0]    b_wptr,
    input  logic                  full,
    output logic                  w_en,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [PTR_WIDTH:0]    wlevel,
    output logic                  almost_full,
    output logic [15:0]           stall_cnt,
    input  logic                  stall_clr
);

    localparam logic [31:0]        AF_THRESH_W = 32'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AF_LEVEL    = AF_THRESH_W[PTR_WIDTH:0];

    // Skid buffer
    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  s_ready_q;
    logic                  acc, fire;

    assign acc  = s.s_valid & s_ready_q;
    assign fire = main_valid_q & ~full;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q) begin
            // Skid is always empty when main is empty.
            if (acc) begin
                main_valid_d = 1'b1;
                main_data_d  = s.s_data;
            end
        end else if (!fire) begin
            if (acc) begin
                skid_valid_d = 1'b1;
                skid_data_d  = s.s_data;
            end
        end else if (skid_valid_q) begin
            // s_ready is low while skid holds data, so no new beat can arrive here.
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (acc) begin
            main_data_d = s.s_data;
        end else begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= ~skid_valid_d;
        end
    end

    assign s.s_ready = s_ready_q;
    assign w_en      = main_valid_q;  // pointer handler gates with !full itself
    assign wdata     = main_data_q;

    // Read-pointer synchroniser: plain flop chain, nothing between stages.
    logic [PTR_WIDTH:0] sync_q [SYNC_STAGES];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_rptr_async;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_rptr_sync = sync_q[SYNC_STAGES-1];

    // Level, almost_full, stall counter
    logic [PTR_WIDTH:0] rbin;
    logic [PTR_WIDTH:0] wlevel_q;
    logic               almost_full_q;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    always_comb begin
        rbin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
        for (int i = int'(PTR_WIDTH) - 1; i >= 0; i--) begin
            rbin[i] = rbin[i+1] ^ g_rptr_sync[i];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_clr) begin
            stall_cnt_d = '0;
        end else if (main_valid_q && full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel_q      <= '0;
            almost_full_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // Modulo subtraction handles pointer wrap; max result is DEPTH.
            wlevel_q      <= b_wptr - rbin;
            almost_full_q <= (wlevel_q >= AF_LEVEL);
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
module tb_wr_ingress_ctrl;

    localparam int SYNC = 2;
    localparam int AF   = 6;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic [3:0] g_rptr_async;
    logic [3:0] g_rptr_sync;
    logic [3:0] b_wptr;
    logic       full;
    logic       w_en;
    logic [7:0] wdata;
    logic [3:0] wlevel;
    logic       almost_full;
    logic [15:0] stall_cnt;
    logic       stall_clr;

    wr_ingress_ctrl_if #(.DATA_WIDTH(8)) sif ();

    wr_ingress_ctrl #(
        .DATA_WIDTH (8),
        .PTR_WIDTH  (3),
        .SYNC_STAGES(SYNC),
        .AF_THRESH  (AF)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .s           (sif),
        .g_rptr_async(g_rptr_async),
        .g_rptr_sync (g_rptr_sync),
        .b_wptr      (b_wptr),
        .full        (full),
        .w_en        (w_en),
        .wdata       (wdata),
        .wlevel      (wlevel),
        .almost_full (almost_full),
        .stall_cnt   (stall_cnt),
        .stall_clr   (stall_clr)
    );

    always #5 wclk = ~wclk;

    int checks   = 0;
    int failures = 0;

    // Reference model: beats held by the stage, in order of arrival.
    logic [7:0] q[$];
    logic [3:0] rhist [SYNC];
    logic [3:0] exp_wlevel;
    logic       exp_af;
    int         exp_stall;
    logic [3:0] wp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b = g;
        for (int sh = 1; sh < 4; sh++) b = b ^ (g >> sh);
        return b;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < SYNC; i++) rhist[i] = '0;
        exp_wlevel = '0;
        exp_af     = 1'b0;
        exp_stall  = 0;
        wp         = '0;
    endtask

    task automatic check_all();
        chk("s_ready", 32'(sif.s_ready), 32'(q.size() < 2));
        chk("w_en", 32'(w_en), 32'(q.size() > 0));
        if (q.size() > 0) chk("wdata", 32'(wdata), 32'(q[0]));
        chk("g_rptr_sync", 32'(g_rptr_sync), 32'(rhist[SYNC-1]));
        chk("wlevel", 32'(wlevel), 32'(exp_wlevel));
        chk("almost_full", 32'(almost_full), 32'(exp_af));
        chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    endtask

    // One clock: drive inputs at negedge, advance model at posedge, compare 1 time unit later.
    task automatic cycle(input logic v, input logic [7:0] d, input logic f,
                         input logic [3:0] g, input logic [3:0] bw, input logic clr);
        logic acc_m, fire_m;
        @(negedge wclk);
        sif.s_valid  = v;
        sif.s_data   = d;
        full         = f;
        g_rptr_async = g;
        b_wptr       = bw;
        stall_clr    = clr;
        @(posedge wclk);
        acc_m  = v && (q.size() < 2);
        fire_m = (q.size() > 0) && !f;
        if (clr) exp_stall = 0;
        else if ((q.size() > 0) && f && exp_stall < 65535) exp_stall++;
        exp_af     = (exp_wlevel >= 4'(AF));
        exp_wlevel = bw - g2b(rhist[SYNC-1]);
        for (int i = SYNC - 1; i > 0; i--) rhist[i] = rhist[i-1];
        rhist[0] = g;
        if (fire_m) begin
            void'(q.pop_front());
            wp = wp + 4'd1;
        end
        if (acc_m) q.push_back(d);
        #1;
        check_all();
    endtask

    initial begin
        wrst_n       = 1'b0;
        sif.s_valid  = 1'b0;
        sif.s_data   = '0;
        full         = 1'b0;
        g_rptr_async = '0;
        b_wptr       = '0;
        stall_clr    = 1'b0;
        model_reset();
        repeat (3) @(posedge wclk);
        #1;
        chk("rst_s_ready", 32'(sif.s_ready), 32'd1);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Idle
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);

        // Stream 0x10..0x17 back to back, write pointer follows the writes
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 4'h0, wp, 1'b0);
        // 0x17 fires while 0x18 is accepted; then the handler reports full
        cycle(1'b1, 8'h18, 1'b0, 4'h0, wp, 1'b0);
        chk("wp_after_8", 32'(wp), 32'd8);
        cycle(1'b1, 8'h19, 1'b1, 4'h0, wp, 1'b0);
        chk("skid_ready_low", 32'(sif.s_ready), 32'd0);
        repeat (4) cycle(1'b1, 8'h1A, 1'b1, 4'h0, wp, 1'b0);
        chk("full_wlevel", 32'(wlevel), 32'd8);
        chk("full_af", 32'(almost_full), 32'd1);
        chk("held_wdata", 32'(wdata), 32'h18);
        chk("stall_5", 32'(stall_cnt), 32'd5);
        // Release full: 0x18 then 0x19 drain on consecutive cycles
        cycle(1'b0, 8'h00, 1'b0, 4'h0, wp, 1'b0);
        chk("drain_wdata_19", 32'(wdata), 32'h19);
        cycle(1'b0, 8'h00, 1'b0, 4'h0, wp, 1'b0);
        chk("drain_empty", 32'(w_en), 32'd0);
        chk("drain_ready", 32'(sif.s_ready), 32'd1);

        // Level with read pointer bin 4 and write pointer 10
        repeat (SYNC + 1) cycle(1'b0, 8'h00, 1'b0, 4'b0110, 4'b1010, 1'b0);
        chk("level_6", 32'(wlevel), 32'd6);
        // Wrapped write pointer: 1 - 12 mod 16 = 5
        repeat (SYNC + 1) cycle(1'b0, 8'h00, 1'b0, 4'b1010, 4'b0001, 1'b0);
        chk("level_wrap_5", 32'(wlevel), 32'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                  4'($urandom), 4'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        // Drain, then saturate the stall counter
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b1);
        cycle(1'b1, 8'h55, 1'b1, 4'h0, 4'h0, 1'b0);
        repeat (65540) cycle(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
        cycle(1'b0, 8'h00, 1'b1, 4'h0, 4'h0, 1'b1);
        chk("stall_clr", 32'(stall_cnt), 32'd0);

        // Fill the skid entry, then reset mid-transfer
        cycle(1'b1, 8'h66, 1'b1, 4'h3, 4'h0, 1'b0);
        chk("pre_rst_ready", 32'(sif.s_ready), 32'd0);
        #1;
        wrst_n = 1'b0;
        #1;
        chk("arst_s_ready", 32'(sif.s_ready), 32'd1);
        chk("arst_w_en", 32'(w_en), 32'd0);
        chk("arst_wdata", 32'(wdata), 32'd0);
        chk("arst_sync", 32'(g_rptr_sync), 32'd0);
        chk("arst_wlevel", 32'(wlevel), 32'd0);
        chk("arst_af", 32'(almost_full), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        model_reset();
        #1;
        wrst_n = 1'b1;
        cycle(1'b1, 8'hA5, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("post_rst_wdata", 32'(wdata), 32'hA5);
        cycle(1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("post_rst_empty", 32'(w_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
